// File: rtl/accumulating_adder_if.sv
// Operand/result bundle for the accumulating adder.
// The master side drives operands and mode; the slave side returns the registered result and flags.
interface accumulating_adder_if #(
  parameter int SIZE = 6
);
  logic            i_VALID_IN;
  logic [1:0]      i_MODE;
  logic [SIZE-1:0] i_VECTOR_ONE;
  logic [SIZE-1:0] i_VECTOR_TWO;
  logic [SIZE:0]   o_VECTOR_SUM;
  logic            o_VALID_OUT;
  logic            o_BIT_BORROW;
  logic            o_BIT_OVERFLOW;

  modport master (
    output i_VALID_IN, i_MODE, i_VECTOR_ONE, i_VECTOR_TWO,
    input  o_VECTOR_SUM, o_VALID_OUT, o_BIT_BORROW, o_BIT_OVERFLOW
  );

  modport slave (
    input  i_VALID_IN, i_MODE, i_VECTOR_ONE, i_VECTOR_TWO,
    output o_VECTOR_SUM, o_VALID_OUT, o_BIT_BORROW, o_BIT_OVERFLOW
  );
endinterface

// File: rtl/accumulating_adder.sv
// Registered add / subtract / accumulate unit with a sticky overflow flag.
// Every output is a flop; one valid input cycle yields one o_VALID_OUT pulse a cycle later.
// The accumulator is SIZE+1 bits wide, and SATURATE picks wrap (0) or clamp (1) on overflow.
module accumulating_adder #(
  parameter int SIZE     = 6,
  parameter int SATURATE = 0
) (
  input logic                 i_CLOCK_POS,
  input logic                 i_RESET_NEG,
  accumulating_adder_if.slave bus
);

  localparam int W = SIZE + 1;
  localparam logic [W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SUB   = 2'b01,
    MODE_ACC   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] sum_q, sum_d;
  logic         valid_q, valid_d;
  logic         borrow_q, borrow_d;
  logic         overflow_q, overflow_d;

  logic [W-1:0] opOne, opTwo;
  logic [W:0]   accWide;
  logic         accCarry;

  // Operands are zero-extended to the result width; the accumulator sum keeps one extra bit to expose the carry-out.
  always_comb begin
    opOne    = {1'b0, bus.i_VECTOR_ONE};
    opTwo    = {1'b0, bus.i_VECTOR_TWO};
    accWide  = {1'b0, acc_q} + {1'b0, opOne};
    accCarry = accWide[W];
  end

  // Next-state selection: hold everything when no valid operation arrives, otherwise apply the requested mode.
  always_comb begin
    acc_d      = acc_q;
    sum_d      = sum_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    valid_d    = bus.i_VALID_IN;
    if (bus.i_VALID_IN) begin
      case (mode_e'(bus.i_MODE))
        MODE_ADD: begin
          sum_d    = opOne + opTwo;
          borrow_d = 1'b0;
        end
        MODE_SUB: begin
          sum_d    = opOne - opTwo;
          borrow_d = (bus.i_VECTOR_TWO > bus.i_VECTOR_ONE);
        end
        MODE_ACC: begin
          if (accCarry) begin
            overflow_d = 1'b1;
            acc_d      = (SATURATE != 0) ? ACC_MAX : accWide[W-1:0];
          end else begin
            acc_d = accWide[W-1:0];
          end
          sum_d    = acc_d;
          borrow_d = 1'b0;
        end
        MODE_CLEAR: begin
          acc_d      = '0;
          sum_d      = '0;
          borrow_d   = 1'b0;
          overflow_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset clears them asynchronously so a cut-off operation never strobes.
  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      acc_q      <= '0;
      sum_q      <= '0;
      valid_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      valid_q    <= valid_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.o_VECTOR_SUM   = sum_q;
  assign bus.o_VALID_OUT    = valid_q;
  assign bus.o_BIT_BORROW   = borrow_q;
  assign bus.o_BIT_OVERFLOW = overflow_q;

endmodule

// File: tb/tb_accumulating_adder.sv
// Testbench for accumulating_adder: one wrapping and one saturating instance share the same stimulus.
// A behavioural model tracks both; a compare process checks every falling edge, and directed literals pin the model.
module tb_accumulating_adder;

  localparam int SIZE = 6;
  localparam int MAXV = (1 << (SIZE + 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [SIZE-1:0] one = '0;
  logic [SIZE-1:0] two = '0;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  int accM [2];
  int sumM [2];
  bit borM [2];
  bit ovfM [2];
  bit vM [2];

  accumulating_adder_if #(.SIZE(SIZE)) busWrap ();
  accumulating_adder_if #(.SIZE(SIZE)) busSat ();

  assign busWrap.i_VALID_IN   = valid;
  assign busWrap.i_MODE       = mode;
  assign busWrap.i_VECTOR_ONE = one;
  assign busWrap.i_VECTOR_TWO = two;
  assign busSat.i_VALID_IN    = valid;
  assign busSat.i_MODE        = mode;
  assign busSat.i_VECTOR_ONE  = one;
  assign busSat.i_VECTOR_TWO  = two;

  accumulating_adder #(.SIZE(SIZE), .SATURATE(0)) dutWrap (
    .i_CLOCK_POS (clk),
    .i_RESET_NEG (rst_n),
    .bus         (busWrap.slave)
  );

  accumulating_adder #(.SIZE(SIZE), .SATURATE(1)) dutSat (
    .i_CLOCK_POS (clk),
    .i_RESET_NEG (rst_n),
    .bus         (busSat.slave)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Plain-arithmetic accumulator rule: sum, then wrap or clamp when it exceeds the largest representable value.
  function automatic int accNext(input int acc, input int add, input int sat);
    int t;
    t = acc + add;
    if (t > MAXV) return (sat != 0) ? MAXV : t - (MAXV + 1);
    return t;
  endfunction

  // Behavioural model for both instances; index 0 wraps, index 1 saturates.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        accM[k] <= 0;
        sumM[k] <= 0;
        borM[k] <= 1'b0;
        ovfM[k] <= 1'b0;
        vM[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        vM[k] <= valid;
        if (valid) begin
          case (mode)
            2'b00: begin
              sumM[k] <= int'(one) + int'(two);
              borM[k] <= 1'b0;
            end
            2'b01: begin
              sumM[k] <= (int'(one) - int'(two) + MAXV + 1) % (MAXV + 1);
              borM[k] <= (int'(two) > int'(one));
            end
            2'b10: begin
              accM[k] <= accNext(accM[k], int'(one), k);
              sumM[k] <= accNext(accM[k], int'(one), k);
              borM[k] <= 1'b0;
              if (accM[k] + int'(one) > MAXV) ovfM[k] <= 1'b1;
            end
            default: begin
              accM[k] <= 0;
              sumM[k] <= 0;
              borM[k] <= 1'b0;
              ovfM[k] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Compare both DUT instances against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      compareOne("model.sum.wrap", int'(busWrap.o_VECTOR_SUM), sumM[0]);
      compareOne("model.valid.wrap", int'(busWrap.o_VALID_OUT), int'(vM[0]));
      compareOne("model.borrow.wrap", int'(busWrap.o_BIT_BORROW), int'(borM[0]));
      compareOne("model.ovf.wrap", int'(busWrap.o_BIT_OVERFLOW), int'(ovfM[0]));
      compareOne("model.sum.sat", int'(busSat.o_VECTOR_SUM), sumM[1]);
      compareOne("model.valid.sat", int'(busSat.o_VALID_OUT), int'(vM[1]));
      compareOne("model.borrow.sat", int'(busSat.o_BIT_BORROW), int'(borM[1]));
      compareOne("model.ovf.sat", int'(busSat.o_BIT_OVERFLOW), int'(ovfM[1]));
    end
  end

  task automatic compareOne(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Hand-computed expectations for both instances at the current sample point.
  task automatic checkOutput(input string name, input int sumW, input int sumS, input int v,
                             input int bor, input int ovfW, input int ovfS);
    compareOne({name, ".sum.wrap"}, int'(busWrap.o_VECTOR_SUM), sumW);
    compareOne({name, ".sum.sat"}, int'(busSat.o_VECTOR_SUM), sumS);
    compareOne({name, ".valid.wrap"}, int'(busWrap.o_VALID_OUT), v);
    compareOne({name, ".valid.sat"}, int'(busSat.o_VALID_OUT), v);
    compareOne({name, ".borrow.wrap"}, int'(busWrap.o_BIT_BORROW), bor);
    compareOne({name, ".borrow.sat"}, int'(busSat.o_BIT_BORROW), bor);
    compareOne({name, ".ovf.wrap"}, int'(busWrap.o_BIT_OVERFLOW), ovfW);
    compareOne({name, ".ovf.sat"}, int'(busSat.o_BIT_OVERFLOW), ovfS);
  endtask

  // Drive one cycle of inputs from a falling edge and return at the falling edge after the capturing rising edge.
  task automatic applyStimulus(input bit v, input logic [1:0] m, input int a, input int b);
    valid = v;
    mode  = m;
    one   = SIZE'(a);
    two   = SIZE'(b);
    @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    #1 rst_n = 1'b0;
    checkEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 2'b00, 63, 63);
    checkOutput("add63", 126, 126, 1, 0, 0, 0);
    applyStimulus(1'b0, 2'b00, 1, 1);
    checkOutput("addHold", 126, 126, 0, 0, 0, 0);

    applyStimulus(1'b1, 2'b01, 5, 9);
    checkOutput("sub5m9", 124, 124, 1, 1, 0, 0);
    applyStimulus(1'b1, 2'b01, 9, 5);
    checkOutput("sub9m5", 4, 4, 1, 0, 0, 0);

    applyStimulus(1'b1, 2'b11, 0, 0);
    checkOutput("clear1", 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 2'b10, 40, 17);
    checkOutput("acc40a", 40, 40, 1, 0, 0, 0);
    applyStimulus(1'b1, 2'b10, 40, 0);
    checkOutput("acc40b", 80, 80, 1, 0, 0, 0);
    applyStimulus(1'b1, 2'b10, 40, 0);
    checkOutput("acc40c", 120, 120, 1, 0, 0, 0);
    applyStimulus(1'b1, 2'b10, 40, 0);
    checkOutput("acc40d", 32, 127, 1, 0, 1, 1);
    applyStimulus(1'b1, 2'b10, 1, 0);
    checkOutput("acc1", 33, 127, 1, 0, 1, 1);
    applyStimulus(1'b1, 2'b00, 1, 1);
    checkOutput("add1p1", 2, 2, 1, 0, 1, 1);
    applyStimulus(1'b1, 2'b10, 0, 0);
    checkOutput("accResume", 33, 127, 1, 0, 1, 1);
    applyStimulus(1'b1, 2'b11, 0, 0);
    checkOutput("clear2", 0, 0, 1, 0, 0, 0);

    applyStimulus(1'b1, 2'b10, 50, 0);
    checkOutput("acc50", 50, 50, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b10, 10, 0);
      checkOutput("gap", 50, 50, 0, 0, 0, 0);
    end
    applyStimulus(1'b1, 2'b10, 10, 0);
    checkOutput("acc10", 60, 60, 1, 0, 0, 0);

    applyStimulus(1'b1, 2'b11, 0, 0);
    applyStimulus(1'b1, 2'b10, 40, 0);
    applyStimulus(1'b1, 2'b10, 40, 0);
    checkOutput("acc80", 80, 80, 1, 0, 0, 0);
    valid = 1'b1;
    mode  = 2'b10;
    one   = SIZE'(33);
    #2 rst_n = 1'b0;
    #1 checkOutput("midReset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("inReset", 0, 0, 0, 0, 0, 0);
    valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 7, 0);
    checkOutput("acc7", 7, 7, 1, 0, 0, 0);
    applyStimulus(1'b0, 2'b00, 0, 0);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulating_adder.md
ACCUMULATING_ADDER -- requirements
Module: Accumulating_Adder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SIZE, default 6, SHALL set the operand width in bits (SIZE >= 2).
REQ-003 Parameter SATURATE, default 0, SHALL select accumulator overflow behaviour: 0 = wrap, 1 = clamp.
REQ-004 i_CLOCK_POS  input  1  SHALL be the rising-edge clock.
REQ-005 i_RESET_NEG  input  1  SHALL be the asynchronous active-low reset.
REQ-006 i_VALID_IN  input  1  SHALL qualify the operands and mode for the current cycle.
REQ-007 i_MODE  input  2  SHALL select the operation: 00 ADD, 01 SUB, 10 ACC, 11 CLEAR.
REQ-008 i_VECTOR_ONE  input  SIZE  SHALL be operand A, unsigned.
REQ-009 i_VECTOR_TWO  input  SIZE  SHALL be operand B, unsigned.
REQ-010 o_VECTOR_SUM  output  SIZE+1  SHALL be the registered result.
REQ-011 o_VALID_OUT  output  1  SHALL be a one-cycle strobe marking a new o_VECTOR_SUM.
REQ-012 o_BIT_BORROW  output  1  SHALL flag the last SUB result as negative.
REQ-013 o_BIT_OVERFLOW  output  1  SHALL be the sticky accumulator overflow flag.

Function
REQ-014 All outputs SHALL be registered, with one cycle of latency from a valid input cycle to o_VALID_OUT=1.
REQ-015 o_VALID_OUT SHALL equal i_VALID_IN delayed by one clock; it SHALL never be high for two cycles from one input cycle.
REQ-016 With i_VALID_IN=0, o_VECTOR_SUM, o_BIT_BORROW, o_BIT_OVERFLOW and the internal accumulator SHALL hold their values.
REQ-017 ADD: o_VECTOR_SUM SHALL be ONE+TWO, zero-extended to SIZE+1 bits; it cannot overflow; o_BIT_BORROW SHALL be 0; the accumulator SHALL be unchanged.
REQ-018 SUB: o_VECTOR_SUM SHALL be (ONE-TWO) mod 2^(SIZE+1); o_BIT_BORROW SHALL be 1 if TWO > ONE, else 0; the accumulator SHALL be unchanged.
REQ-019 ACC: the SIZE+1-bit accumulator SHALL be updated to ACC+ONE; o_VECTOR_SUM SHALL show the new accumulator value; i_VECTOR_TWO SHALL be ignored; o_BIT_BORROW SHALL be 0.
REQ-020 ACC overflow occurs when ACC+ONE > 2^(SIZE+1)-1. On overflow, o_BIT_OVERFLOW SHALL be set and remain set until CLEAR or reset.
REQ-021 Overflow with SATURATE=0: the accumulator SHALL wrap to (ACC+ONE) mod 2^(SIZE+1).
REQ-022 Overflow with SATURATE=1: the accumulator SHALL clamp to 2^(SIZE+1)-1 and stay there while further ACC cycles arrive.
REQ-023 CLEAR: the accumulator, o_VECTOR_SUM, o_BIT_OVERFLOW and o_BIT_BORROW SHALL all go to 0 on the next edge, and o_VALID_OUT SHALL pulse.
REQ-024 Back-to-back valid ACC cycles SHALL each accumulate with no bubble; throughput SHALL be one operation per clock.
REQ-025 An ADD or SUB between ACC cycles SHALL NOT disturb the accumulator; the next ACC SHALL continue from the stored value.

Reset
REQ-026 Assertion of i_RESET_NEG=0 SHALL immediately force the accumulator, o_VECTOR_SUM, o_VALID_OUT, o_BIT_BORROW and o_BIT_OVERFLOW to 0, independent of the clock.
REQ-027 While reset is asserted, all inputs SHALL be ignored.
REQ-028 A reset asserted mid-accumulation SHALL discard the accumulated value; there SHALL be no o_VALID_OUT pulse for an operation cut off by reset.
REQ-029 The first valid cycle after deassertion SHALL be processed normally.

Verification (SIZE=6)
REQ-030 ADD, ONE=63, TWO=63, valid 1 cycle -> next cycle o_VECTOR_SUM=126, o_VALID_OUT=1 for exactly one cycle, borrow=0.
REQ-031 SUB, ONE=5, TWO=9 -> o_VECTOR_SUM=124, o_BIT_BORROW=1; then SUB 9-5 -> 4, borrow=0.
REQ-032 SATURATE=0: CLEAR, then ACC 40 four times -> sums 40, 80, 120, 32; o_BIT_OVERFLOW=1 from the fourth result onward; a following ADD 1+1 -> 2 with overflow still 1; CLEAR -> 0, overflow=0.
REQ-033 SATURATE=1: the same sequence -> 40, 80, 120, 127, and a further ACC 1 -> 127; overflow=1.
REQ-034 ACC 50, then valid low for 3 cycles, then ACC 10 -> sum holds 50 and valid=0 during the gap, then 60.
REQ-035 After ACC to 80, assert reset between edges -> all outputs 0 immediately; after release, ACC 7 -> 7.
